// File: rtl/gb80_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb80_bus_arbiter_pkg
// Description : Shared owner encodings and MMIO address constants for the
//               external memory bus arbiter and its bus multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package gb80_bus_arbiter_pkg;

    // Current owner of the external memory bus.
    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_DMA = 2'd1,
        OWN_DBG = 2'd2
    } owner_e;

    // Timer MMIO register window (DIV .. TAC).
    localparam logic [15:0] MMIO_DIV = 16'hFF04;
    localparam logic [15:0] MMIO_TAC = 16'hFF07;

    // The debug hold counter is 8 bits wide and saturates at this value.
    localparam logic [7:0]  c_HOLD_SAT = 8'hFF;

endpackage : gb80_bus_arbiter_pkg
`default_nettype wire

// File: rtl/gb80_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : gb80_bus_arbiter_if
// Description : Request/grant and muxed-bus signals of the external memory
//               bus arbiter. The shared tri-state data_ext stays a plain
//               inout port on the arbiter.
//   master : requesting side - drives the CPU, DMA and debug address, write
//            data, strobes and requests; observes grants, the muxed bus,
//            timer_sel and rdata.
//   slave  : arbiter side - the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface gb80_bus_arbiter_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_re;
    logic        cpu_we;

    logic        dma_req;
    logic        dma_lock;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_re;
    logic        dma_we;

    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_re;
    logic        dbg_we;

    logic        dma_gnt;
    logic        dbg_gnt;
    logic        cpu_mem_disable;
    logic [15:0] addr_ext;
    logic        mem_re;
    logic        mem_we;
    logic        timer_sel;
    logic [7:0]  rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_re, cpu_we,
        output dma_req, dma_lock, dma_addr, dma_wdata, dma_re, dma_we,
        output dbg_req, dbg_addr, dbg_wdata, dbg_re, dbg_we,
        input  dma_gnt, dbg_gnt, cpu_mem_disable, addr_ext,
        input  mem_re, mem_we, timer_sel, rdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_re, cpu_we,
        input  dma_req, dma_lock, dma_addr, dma_wdata, dma_re, dma_we,
        input  dbg_req, dbg_addr, dbg_wdata, dbg_re, dbg_we,
        output dma_gnt, dbg_gnt, cpu_mem_disable, addr_ext,
        output mem_re, mem_we, timer_sel, rdata
    );

endinterface : gb80_bus_arbiter_if
`default_nettype wire

// File: rtl/gb80_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : gb80_bus_mux
// Description : Combinational owner-select mux for address, write data and
//               strobes, plus the tri-state driver for the shared data bus.
// Ports       : i_owner        - current bus owner (owner_e encoding)
//               i_bus_en       - 0 suppresses strobes and the data driver
//               i_<m>_addr/wdata/re/we - per-master bus request fields
//               o_addr/o_re/o_we - selected owner's address and strobes
//               io_data        - shared data bus, driven only on owner write
// Revision    : 1.0 - initial release
// ============================================================================
module gb80_bus_mux
    import gb80_bus_arbiter_pkg::*;
(
    input  wire [1:0]  i_owner,
    input  wire        i_bus_en,
    input  wire [15:0] i_cpu_addr,
    input  wire [7:0]  i_cpu_wdata,
    input  wire        i_cpu_re,
    input  wire        i_cpu_we,
    input  wire [15:0] i_dma_addr,
    input  wire [7:0]  i_dma_wdata,
    input  wire        i_dma_re,
    input  wire        i_dma_we,
    input  wire [15:0] i_dbg_addr,
    input  wire [7:0]  i_dbg_wdata,
    input  wire        i_dbg_re,
    input  wire        i_dbg_we,
    output logic [15:0] o_addr,
    output logic        o_re,
    output logic        o_we,
    inout  wire  [7:0]  io_data
);

    logic [7:0] w_wdata;
    logic       w_re;
    logic       w_we;

    // Non-owners are simply not selected, so their strobes never reach the bus.
    always_comb begin
        o_addr  = i_cpu_addr;
        w_wdata = i_cpu_wdata;
        w_re    = i_cpu_re;
        w_we    = i_cpu_we;
        case (i_owner)
            OWN_DMA: begin
                o_addr  = i_dma_addr;
                w_wdata = i_dma_wdata;
                w_re    = i_dma_re;
                w_we    = i_dma_we;
            end
            OWN_DBG: begin
                o_addr  = i_dbg_addr;
                w_wdata = i_dbg_wdata;
                w_re    = i_dbg_re;
                w_we    = i_dbg_we;
            end
            default: ;
        endcase
        o_re = w_re & i_bus_en;
        o_we = w_we & i_bus_en;
    end

    assign io_data = o_we ? w_wdata : 8'bz;

endmodule : gb80_bus_mux
`default_nettype wire

// File: rtl/gb80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gb80_bus_arbiter
// Description : Shares the external memory bus between CPU, OAM DMA and the
//               debug/loader port. Bus parks on the CPU; DMA has priority
//               with burst lock; debug ownership is limited while the CPU
//               waits. Reads in the timer MMIO window are kept off main memory.
// Ports       : clock, reset  - system clock, synchronous active-high reset
//               bus (slave)   - requests/strobes in; grants, cpu_mem_disable,
//                               addr_ext, mem_re/mem_we, timer_sel, rdata out
//               data_ext      - shared tri-state data bus
// Revision    : 1.0 - initial release
// ============================================================================
module gb80_bus_arbiter
    import gb80_bus_arbiter_pkg::*;
#(
    parameter int          MAX_DBG_HOLD = 64,
    parameter logic [15:0] TIMER_LO     = MMIO_DIV,
    parameter logic [15:0] TIMER_HI     = MMIO_TAC
) (
    input  wire              clock,
    input  wire              reset,
    gb80_bus_arbiter_if.slave bus,
    inout  wire [7:0]        data_ext
);

    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_DBG_HOLD);

    owner_e      r_owner;
    owner_e      w_owner_nxt;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_cnt_nxt;
    logic        w_cpu_waiting;
    logic        w_dbg_hold_ok;
    logic [15:0] w_addr;
    logic        w_re;
    logic        w_we;
    logic        w_timer_sel;

    // ------------------------------------------------------------------
    // Arbitration (next owner)
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_nxt   = OWN_CPU;
        w_cpu_waiting = bus.cpu_re | bus.cpu_we;

        // Count including the current cycle, so debug owns the bus for
        // exactly MAX_DBG_HOLD CPU-waiting cycles before being pushed off.
        w_hold_cnt_nxt = r_hold_cnt;
        if (w_cpu_waiting && (r_hold_cnt != c_HOLD_SAT)) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
        w_dbg_hold_ok = (w_hold_cnt_nxt < c_HOLD_LIMIT);

        if ((r_owner == OWN_DMA) && (bus.dma_req || bus.dma_lock)) begin
            w_owner_nxt = OWN_DMA;
        end else if (bus.dma_req) begin
            // Never cut a debug write in half; DMA follows once it ends.
            w_owner_nxt = ((r_owner == OWN_DBG) && bus.dbg_we) ? OWN_DBG : OWN_DMA;
        end else if ((r_owner == OWN_DBG) && bus.dbg_req && w_dbg_hold_ok) begin
            w_owner_nxt = OWN_DBG;
        end else if (bus.dbg_req && (r_owner != OWN_DBG)) begin
            // An owner of DBG reaching here has expired its hold: the CPU
            // gets one cycle before debug may come back.
            w_owner_nxt = OWN_DBG;
        end else begin
            w_owner_nxt = OWN_CPU;
        end
    end

    // ------------------------------------------------------------------
    // Owner and hold counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner    <= OWN_CPU;
            r_hold_cnt <= 8'd0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_owner_nxt != r_owner) begin
                r_hold_cnt <= 8'd0;
            end else if (r_owner == OWN_DBG) begin
                r_hold_cnt <= w_hold_cnt_nxt;
            end
        end
    end

    assign bus.dma_gnt         = (r_owner == OWN_DMA);
    assign bus.dbg_gnt         = (r_owner == OWN_DBG);
    assign bus.cpu_mem_disable = (r_owner != OWN_CPU);

    // ------------------------------------------------------------------
    // Bus mux; strobes and the data driver are held off during reset
    // ------------------------------------------------------------------
    gb80_bus_mux u_bus_mux (
        .i_owner     (r_owner),
        .i_bus_en    (~reset),
        .i_cpu_addr  (bus.cpu_addr),
        .i_cpu_wdata (bus.cpu_wdata),
        .i_cpu_re    (bus.cpu_re),
        .i_cpu_we    (bus.cpu_we),
        .i_dma_addr  (bus.dma_addr),
        .i_dma_wdata (bus.dma_wdata),
        .i_dma_re    (bus.dma_re),
        .i_dma_we    (bus.dma_we),
        .i_dbg_addr  (bus.dbg_addr),
        .i_dbg_wdata (bus.dbg_wdata),
        .i_dbg_re    (bus.dbg_re),
        .i_dbg_we    (bus.dbg_we),
        .o_addr      (w_addr),
        .o_re        (w_re),
        .o_we        (w_we),
        .io_data     (data_ext)
    );

    assign w_timer_sel   = (w_addr >= TIMER_LO) && (w_addr <= TIMER_HI);
    assign bus.addr_ext  = w_addr;
    assign bus.timer_sel = w_timer_sel;
    assign bus.mem_re    = w_re & ~w_timer_sel;
    assign bus.mem_we    = w_we;
    assign bus.rdata     = data_ext;

endmodule : gb80_bus_arbiter
`default_nettype wire
